// File: rtl/platform_collision.sv
// Frame-synchronous doodle/platform landing detector: scans one slot per cycle and registers the first hit.
// PLATFORM_COLLISION_EARTH_FLOOR_EN makes the floor at EARTH count as a landing; CLK/FPS must exceed NUM_PLATFORMS+3.
module platform_collision #(
   parameter int CLK            = 50_000_000,
   parameter int FPS            = 60,
   parameter int NUM_PLATFORMS  = 8,
   parameter int PLATFORM_WIDTH = 120,
   parameter int DOODLE_WIDTH   = 80,
   parameter int DOODLE_HEIGHT  = 80,
   parameter int LAND_TOL       = 12,
   parameter int SHIFT_LINE     = 300,
   parameter int EARTH          = 1000
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [$clog2(CLK/FPS):0]              fps_counter,
   input  logic [1:0]                            game_state,
   input  logic [10:0]                           doodle_x,
   input  logic [9:0]                            doodle_y,
   input  logic                                  doodle_fall_direction,
   input  logic [NUM_PLATFORMS-1:0][10:0]        platform_x,
   input  logic [NUM_PLATFORMS-1:0][9:0]         platform_y,
   input  logic [NUM_PLATFORMS-1:0]              platform_valid,
   output logic                                  collision,
   output logic [1:0][9:0]                       ground,
   output logic                                  move_collision,
   output logic [$clog2(NUM_PLATFORMS)-1:0]      hit_index
);

   localparam int IW = $clog2(NUM_PLATFORMS);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t        state;
   logic [IW-1:0] scan_idx;
   logic [10:0]   snap_x;
   logic [9:0]    snap_y;
   logic          snap_fall;
   logic          hit_found;
   logic [IW-1:0] hit_slot;
   logic [9:0]    hit_y;

   logic [11:0] feet, px, py, dx;
   logic        slot_hit;
   logic        floor_hit;

   // All geometry is widened to 12 bits so no sum can wrap.
   always_comb begin
      feet     = {2'b00, snap_y} + 12'(DOODLE_HEIGHT) + 12'd1;
      dx       = {1'b0, snap_x};
      px       = {1'b0, platform_x[scan_idx]};
      py       = {2'b00, platform_y[scan_idx]};
      slot_hit = platform_valid[scan_idx] && snap_fall &&
                 (feet >= py) && (feet <= py + 12'(LAND_TOL)) &&
                 (dx + 12'(DOODLE_WIDTH) > px) && (dx < px + 12'(PLATFORM_WIDTH));
`ifdef PLATFORM_COLLISION_EARTH_FLOOR_EN
      floor_hit = snap_fall && (feet >= 12'(EARTH));
`else
      floor_hit = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         collision      <= 1'b0;
         move_collision <= 1'b0;
         ground         <= {10'(EARTH), 10'(EARTH)};
         hit_index      <= '0;
         scan_idx       <= '0;
         snap_x         <= '0;
         snap_y         <= '0;
         snap_fall      <= 1'b0;
         hit_found      <= 1'b0;
         hit_slot       <= '0;
         hit_y          <= '0;
      end else if (game_state != 2'd1) begin
         state          <= IDLE;
         collision      <= 1'b0;
         move_collision <= 1'b0;
      end else if ((state == IDLE || state == SCAN) && fps_counter == '0) begin
         // A frame tick during SCAN restarts the scan with a fresh snapshot.
         state          <= SCAN;
         snap_x         <= doodle_x;
         snap_y         <= doodle_y;
         snap_fall      <= doodle_fall_direction;
         collision      <= 1'b0;
         move_collision <= 1'b0;
         scan_idx       <= '0;
         hit_found      <= 1'b0;
      end else begin
         case (state)
            SCAN: begin
               if (slot_hit && !hit_found) begin
                  hit_found <= 1'b1;
                  hit_slot  <= scan_idx;
                  hit_y     <= platform_y[scan_idx];
               end
               if (scan_idx == IW'(NUM_PLATFORMS - 1))
                  state <= DONE;
               else
                  scan_idx <= scan_idx + 1'b1;
            end
            DONE: begin
               if (hit_found) begin
                  collision      <= 1'b1;
                  ground[1]      <= ground[0];
                  ground[0]      <= hit_y;
                  hit_index      <= hit_slot;
                  move_collision <= ({2'b00, hit_y} < 12'(SHIFT_LINE));
               end else if (floor_hit) begin
                  collision      <= 1'b1;
                  ground[1]      <= ground[0];
                  ground[0]      <= 10'(EARTH);
                  move_collision <= 1'b0;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
